// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus the
// valid/ready channel that hands fetched instructions to decode.
interface fetch_unit_if #(
    parameter int ADDR_WIDTH  = 16,
    parameter int INSTR_WIDTH = 16
);
    logic                   imem_req;
    logic [ADDR_WIDTH-1:0]  imem_addr;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic                   id_valid;
    logic                   id_ready;
    logic [INSTR_WIDTH-1:0] id_instr;
    logic [ADDR_WIDTH-1:0]  id_pc;
    logic [ADDR_WIDTH-1:0]  id_pc_next;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_next,
        input  imem_rdata, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_next,
        output imem_rdata, id_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues 1-cycle-latency
// imem reads and buffers returned instructions in a small prefetch queue.
module fetch_unit #(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    INSTR_WIDTH = 16,
    parameter int                    PC_STEP     = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = {ADDR_WIDTH{1'b0}},
    parameter int                    QUEUE_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    input  logic                  halt,
    output logic                  halted,
    fetch_unit_if.master          bus
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(QUEUE_DEPTH);
    localparam logic [CNT_W-1:0]      CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0]      PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] STEP_C  = ADDR_WIDTH'(PC_STEP);

    logic [ADDR_WIDTH-1:0]  fetch_pc_r;
    logic [ADDR_WIDTH-1:0]  req_addr_r;
    logic                   inflight_r;
    logic                   halted_r;
    logic [CNT_W-1:0]       count_r;
    logic [PTR_W-1:0]       head_r;
    logic [PTR_W-1:0]       tail_r;
    logic [INSTR_WIDTH-1:0] instr_mem_r [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0]  pc_mem_r    [QUEUE_DEPTH];

    logic [CNT_W-1:0] occupancy_s;
    logic             valid_s;
    logic             issue_s;
    logic             push_s;
    logic             pop_s;

    // Slots already promised to an in-flight read count as occupied, so the
    // queue can never be overrun by the response that follows an issue.
    assign occupancy_s = count_r + {{(CNT_W-1){1'b0}}, inflight_r};
    assign valid_s     = !reset && (count_r != {CNT_W{1'b0}});
    assign issue_s     = !reset && !halted_r && !redirect && (occupancy_s < DEPTH_C);
    assign push_s      = inflight_r && !redirect;
    assign pop_s       = valid_s && bus.id_ready && !redirect;

    assign bus.imem_req   = issue_s;
    assign bus.imem_addr  = fetch_pc_r;
    assign bus.id_valid   = valid_s;
    assign bus.id_instr   = instr_mem_r[head_r];
    assign bus.id_pc      = pc_mem_r[head_r];
    assign bus.id_pc_next = pc_mem_r[head_r] + STEP_C;
    assign halted         = halted_r;

    // Fetch PC, in-flight tracking, halt latch and queue bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_r <= RESET_ADDR;
            inflight_r <= 1'b0;
            halted_r   <= 1'b0;
            count_r    <= {CNT_W{1'b0}};
            head_r     <= {PTR_W{1'b0}};
            tail_r     <= {PTR_W{1'b0}};
        end else begin
            if (halt) begin
                halted_r <= 1'b1;
            end
            if (redirect) begin
                fetch_pc_r <= redirect_addr;
                inflight_r <= 1'b0;
                count_r    <= {CNT_W{1'b0}};
                head_r     <= {PTR_W{1'b0}};
                tail_r     <= {PTR_W{1'b0}};
            end else begin
                if (issue_s) begin
                    fetch_pc_r <= fetch_pc_r + STEP_C;
                    req_addr_r <= fetch_pc_r;
                    inflight_r <= 1'b1;
                end else begin
                    inflight_r <= 1'b0;
                end
                if (push_s) begin
                    tail_r <= tail_r + PTR_ONE;
                end
                if (pop_s) begin
                    head_r <= head_r + PTR_ONE;
                end
                if (push_s && !pop_s) begin
                    count_r <= count_r + CNT_ONE;
                end else if (pop_s && !push_s) begin
                    count_r <= count_r - CNT_ONE;
                end
            end
        end
    end

    // Queue payload storage; needs no reset because count gates visibility.
    always_ff @(posedge clock) begin
        if (!reset && push_s) begin
            instr_mem_r[tail_r] <= bus.imem_rdata;
            pc_mem_r[tail_r]    <= req_addr_r;
        end
    end

    fetch_unit_chk #(
        .CNT_W       (CNT_W),
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_chk (
        .clock (clock),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .count (count_r)
    );
endmodule

// Safety checker: a response must always find a free queue slot.
module fetch_unit_chk #(
    parameter int CNT_W       = 3,
    parameter int QUEUE_DEPTH = 4
) (
    input logic             clock,
    input logic             reset,
    input logic             push,
    input logic             pop,
    input logic [CNT_W-1:0] count
);
    logic full_s;
    assign full_s = (count == CNT_W'(QUEUE_DEPTH));

    a_no_overflow: assert property (@(posedge clock) disable iff (reset) !(push && full_s && !pop))
        else $error("fetch_unit: push into full prefetch queue");
endmodule

// File: tb/tb_fetch_unit.sv
// Directed and random stimulus driving three fetch_unit configurations in
// lock-step, each checked every cycle against a queue-based reference model.
module tb_fetch_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic        halt = 1'b0;
    logic        id_ready = 1'b0;
    logic [31:0] redirect_addr = 32'h0;
    logic        halted0, halted1, halted2;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    fetch_unit_if #(.ADDR_WIDTH(16), .INSTR_WIDTH(16)) if0 ();
    fetch_unit_if #(.ADDR_WIDTH(16), .INSTR_WIDTH(16)) if1 ();
    fetch_unit_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) if2 ();

    fetch_unit #(.ADDR_WIDTH(16), .INSTR_WIDTH(16), .PC_STEP(2), .RESET_ADDR(16'h0000), .QUEUE_DEPTH(4)) u_dut0 (
        .clock(clock), .reset(reset), .redirect(redirect), .redirect_addr(redirect_addr[15:0]),
        .halt(halt), .halted(halted0), .bus(if0.master));
    fetch_unit #(.ADDR_WIDTH(16), .INSTR_WIDTH(16), .PC_STEP(2), .RESET_ADDR(16'hFFFC), .QUEUE_DEPTH(4)) u_dut1 (
        .clock(clock), .reset(reset), .redirect(redirect), .redirect_addr(redirect_addr[15:0]),
        .halt(halt), .halted(halted1), .bus(if1.master));
    fetch_unit #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .PC_STEP(4), .RESET_ADDR(32'h0), .QUEUE_DEPTH(8)) u_dut2 (
        .clock(clock), .reset(reset), .redirect(redirect), .redirect_addr(redirect_addr),
        .halt(halt), .halted(halted2), .bus(if2.master));

    function automatic logic [31:0] mk(input logic [31:0] a);
        return a ^ 32'h5AC3_3CA5;
    endfunction

    // Instruction memory: data for the address presented in the previous cycle.
    logic [31:0] last_a [3];
    logic [31:0] rd0, rd1, rd2;
    always @(posedge clock) begin
        last_a[0] <= 32'(if0.imem_addr);
        last_a[1] <= 32'(if1.imem_addr);
        last_a[2] <= if2.imem_addr;
    end
    assign rd0 = mk(last_a[0]);
    assign rd1 = mk(last_a[1]);
    assign rd2 = mk(last_a[2]);
    assign if0.imem_rdata = rd0[15:0];
    assign if1.imem_rdata = rd1[15:0];
    assign if2.imem_rdata = rd2;
    assign if0.id_ready = id_ready;
    assign if1.id_ready = id_ready;
    assign if2.id_ready = id_ready;

    // Reference model per configuration.
    logic [31:0] m_mask [3];
    logic [31:0] m_rst  [3];
    int          m_step [3];
    int          m_depth[3];
    logic [31:0] m_pc   [3];
    logic [31:0] m_q    [3][8];
    int          m_qn   [3];
    bit          m_infl [3];
    logic [31:0] m_infl_a[3];
    bit          m_halted[3];
    bit          m_known[3];

    logic        o_req  [3];
    logic        o_valid[3];
    logic        o_halted[3];
    logic [31:0] o_addr [3];
    logic [31:0] o_instr[3];
    logic [31:0] o_pc   [3];
    logic [31:0] o_pcn  [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        o_req[0] = if0.imem_req;  o_valid[0] = if0.id_valid;  o_halted[0] = halted0;
        o_addr[0] = 32'(if0.imem_addr); o_instr[0] = 32'(if0.id_instr);
        o_pc[0] = 32'(if0.id_pc); o_pcn[0] = 32'(if0.id_pc_next);
        o_req[1] = if1.imem_req;  o_valid[1] = if1.id_valid;  o_halted[1] = halted1;
        o_addr[1] = 32'(if1.imem_addr); o_instr[1] = 32'(if1.id_instr);
        o_pc[1] = 32'(if1.id_pc); o_pcn[1] = 32'(if1.id_pc_next);
        o_req[2] = if2.imem_req;  o_valid[2] = if2.id_valid;  o_halted[2] = halted2;
        o_addr[2] = if2.imem_addr; o_instr[2] = if2.id_instr;
        o_pc[2] = if2.id_pc; o_pcn[2] = if2.id_pc_next;
    endtask

    task automatic model_cycle(input int k);
        bit e_req, e_valid, push, pop;
        logic [31:0] head;
        e_req   = !reset && !m_halted[k] && !redirect && (m_qn[k] + int'(m_infl[k]) < m_depth[k]);
        e_valid = !reset && (m_qn[k] != 0);
        check($sformatf("d%0d_req", k), {31'b0, o_req[k]}, {31'b0, e_req});
        check($sformatf("d%0d_valid", k), {31'b0, o_valid[k]}, {31'b0, e_valid});
        if (e_req) check($sformatf("d%0d_addr", k), o_addr[k], m_pc[k]);
        if (e_valid) begin
            head = m_q[k][0];
            check($sformatf("d%0d_id_pc", k), o_pc[k], head);
            check($sformatf("d%0d_id_instr", k), o_instr[k], mk(head) & m_mask[k]);
            check($sformatf("d%0d_id_pc_next", k), o_pcn[k], (head + 32'(m_step[k])) & m_mask[k]);
        end
        if (m_known[k] && !reset) check($sformatf("d%0d_halted", k), {31'b0, o_halted[k]}, {31'b0, m_halted[k]});
        if (reset) begin
            m_pc[k] = m_rst[k]; m_qn[k] = 0; m_infl[k] = 0; m_halted[k] = 0; m_known[k] = 1;
        end else begin
            push = m_infl[k] && !redirect;
            pop  = e_valid && id_ready && !redirect;
            if (halt) m_halted[k] = 1;
            if (redirect) begin
                m_qn[k] = 0; m_infl[k] = 0; m_pc[k] = redirect_addr & m_mask[k];
            end else begin
                if (pop) begin
                    for (int i = 0; i < 7; i++) m_q[k][i] = m_q[k][i+1];
                    m_qn[k]--;
                end
                if (push && m_qn[k] < 8) begin
                    m_q[k][m_qn[k]] = m_infl_a[k];
                    m_qn[k]++;
                end
                if (e_req) begin
                    m_infl[k] = 1; m_infl_a[k] = m_pc[k];
                    m_pc[k] = (m_pc[k] + 32'(m_step[k])) & m_mask[k];
                end else begin
                    m_infl[k] = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clock);
        sample();
        for (int k = 0; k < 3; k++) model_cycle(k);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int nreq0, nreq2;
        m_mask[0] = 32'h0000_FFFF; m_rst[0] = 32'h0000_0000; m_step[0] = 2; m_depth[0] = 4;
        m_mask[1] = 32'h0000_FFFF; m_rst[1] = 32'h0000_FFFC; m_step[1] = 2; m_depth[1] = 4;
        m_mask[2] = 32'hFFFF_FFFF; m_rst[2] = 32'h0000_0000; m_step[2] = 4; m_depth[2] = 8;
        for (int k = 0; k < 3; k++) begin
            m_known[k] = 0; m_qn[k] = 0; m_infl[k] = 0; m_halted[k] = 0; m_pc[k] = 32'h0;
        end

        // Streaming from reset, including the 16-bit wrap configuration.
        reset = 1'b1; step(); step();
        reset = 1'b0; id_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            if (c < 3) begin
                check("s1_addr0", o_addr[0], 32'(2 * c));
                check("s1_addr2", o_addr[2], 32'(4 * c));
                check("s1_wrap_addr", o_addr[1], (32'h0000_FFFC + 32'(2 * c)) & 32'h0000_FFFF);
            end
            if (c >= 2) begin
                check("s1_pc0", o_pc[0], 32'(2 * (c - 2)));
                check("s1_pcn0", o_pcn[0], 32'(2 * (c - 1)));
                check("s1_pc2", o_pc[2], 32'(4 * (c - 2)));
            end
            if (c == 3) begin
                check("s1_wrap_pc", o_pc[1], 32'h0000_FFFE);
                check("s1_wrap_pcn", o_pcn[1], 32'h0000_0000);
            end
        end

        // Backpressure from reset.
        reset = 1'b1; id_ready = 1'b0; step();
        reset = 1'b0; nreq0 = 0; nreq2 = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            nreq0 += int'(o_req[0]);
            nreq2 += int'(o_req[2]);
        end
        check("s2_nreq0", 32'(nreq0), 32'd4);
        check("s2_nreq2", 32'(nreq2), 32'd8);
        check("s2_stall_req0", {31'b0, o_req[0]}, 32'd0);
        check("s2_stall_addr0", o_addr[0], 32'd8);
        check("s2_stall_addr2", o_addr[2], 32'd32);
        id_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            check("s2_pop_valid0", {31'b0, o_valid[0]}, 32'd1);
            check("s2_pop_pc0", o_pc[0], 32'(2 * c));
            check("s2_pop_pc2", o_pc[2], 32'(4 * c));
            if (c == 0) check("s2_req_after_pop0", {31'b0, o_req[0]}, 32'd0);
            if (c == 1) begin
                check("s2_reissue_req0", {31'b0, o_req[0]}, 32'd1);
                check("s2_reissue_addr0", o_addr[0], 32'd8);
                check("s2_reissue_addr2", o_addr[2], 32'd32);
            end
        end

        // Redirect with two queued entries and one read in flight.
        reset = 1'b1; id_ready = 1'b0; step();
        reset = 1'b0; step(); step(); step();
        redirect = 1'b1; redirect_addr = 32'h0000_0100; step();
        redirect = 1'b0; id_ready = 1'b1;
        step();
        check("s3_valid_t1", {31'b0, o_valid[0]}, 32'd0);
        check("s3_req_t1", {31'b0, o_req[0]}, 32'd1);
        check("s3_addr_t1", o_addr[0], 32'h0000_0100);
        check("s3_addr2_t1", o_addr[2], 32'h0000_0100);
        step();
        check("s3_valid_t2", {31'b0, o_valid[0]}, 32'd0);
        step();
        check("s3_valid_t3", {31'b0, o_valid[0]}, 32'd1);
        check("s3_pc_t3", o_pc[0], 32'h0000_0100);
        step();
        check("s3_pc_t4", o_pc[0], 32'h0000_0102);

        // Halt mid-stream, then a redirect that must not restart fetch.
        reset = 1'b1; step();
        reset = 1'b0; id_ready = 1'b1;
        for (int c = 0; c < 4; c++) step();
        halt = 1'b1; step();
        check("s5_req_halt_cycle", {31'b0, o_req[0]}, 32'd1);
        halt = 1'b0; step();
        check("s5_req_after", {31'b0, o_req[0]}, 32'd0);
        check("s5_halted", {31'b0, o_halted[0]}, 32'd1);
        for (int c = 0; c < 5; c++) step();
        check("s5_drained", {31'b0, o_valid[0]}, 32'd0);
        redirect = 1'b1; redirect_addr = 32'h0000_0200; step();
        redirect = 1'b0;
        for (int c = 0; c < 4; c++) step();
        check("s5_no_restart_req", {31'b0, o_req[0]}, 32'd0);
        check("s5_no_restart_valid", {31'b0, o_valid[0]}, 32'd0);
        check("s5_still_halted", {31'b0, o_halted[0]}, 32'd1);

        // Reset with a full queue and halted set.
        reset = 1'b1; step();
        reset = 1'b0; id_ready = 1'b0;
        for (int c = 0; c < 6; c++) step();
        halt = 1'b1; step();
        halt = 1'b0; reset = 1'b1; step();
        check("s6_req_in_reset", {31'b0, o_req[0]}, 32'd0);
        check("s6_valid_in_reset", {31'b0, o_valid[0]}, 32'd0);
        step();
        check("s6_valid_after", {31'b0, o_valid[0]}, 32'd0);
        check("s6_halted_after", {31'b0, o_halted[0]}, 32'd0);
        reset = 1'b0; id_ready = 1'b1; step();
        check("s6_first_req", {31'b0, o_req[0]}, 32'd1);
        check("s6_first_addr0", o_addr[0], 32'd0);
        check("s6_first_addr1", o_addr[1], 32'h0000_FFFC);

        // Random traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            id_ready      = ($urandom_range(3) != 0);
            redirect      = ($urandom_range(15) == 0);
            redirect_addr = $urandom & 32'hFFFF_FFFE;
            halt          = ($urandom_range(79) == 0);
            reset         = ($urandom_range(59) == 0);
            step();
        end
        reset = 1'b0; redirect = 1'b0; halt = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
